// File: rtl/mul_issue_if.sv
// mul_issue_if: bundles the request, response and multiplier-side signals of the
// multiply issue stage.
//   flush                  abort the current operation
//   req_valid/req_ready    request handshake; req_op, req_a, req_b, req_tag payload
//   mul_start, mul_in1/2   launch pulse and operand magnitudes to the multiplier
//   mul_done, mul_product  completion pulse and unsigned product from the multiplier
//   rsp_valid/rsp_ready    response handshake; rsp_data, rsp_tag payload
// slave is the issue stage's view; master is the environment's view.
interface mul_issue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic                flush;
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [XLEN-1:0]     req_a;
  logic [XLEN-1:0]     req_b;
  logic [TAG_W-1:0]    req_tag;
  logic                mul_start;
  logic [XLEN-1:0]     mul_in1;
  logic [XLEN-1:0]     mul_in2;
  logic                mul_done;
  logic [2*XLEN-1:0]   mul_product;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_data;
  logic [TAG_W-1:0]    rsp_tag;

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_tag,
    input  mul_done, mul_product, rsp_ready,
    output req_ready, mul_start, mul_in1, mul_in2, rsp_valid, rsp_data, rsp_tag
  );

  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_tag,
    output mul_done, mul_product, rsp_ready,
    input  req_ready, mul_start, mul_in1, mul_in2, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/mul_issue.sv
// mul_issue: issue/sequencing stage in front of an iterative unsigned multiplier.
// Accepts MUL/MULH/MULHSU/MULHU requests, sends operand magnitudes to the multiplier,
// sign-corrects the 2*XLEN product and returns the selected half with the request tag.
// One operation in flight at a time.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   mul_issue_if.slave: flush, request, multiplier and response signals
module mul_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic       clk,
  input logic       rst,
  mul_issue_if.slave bus
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFix,
    StResp,
    StDrain
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  in1_q, in1_d;
  logic [XLEN-1:0]  in2_q, in2_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic             a_signed, b_signed;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             operand_zero;
  logic [PW-1:0]    prod_fixed;

  // Operand decode for the request currently presented.
  always_comb begin
    a_signed     = (bus.req_op == 2'b01) || (bus.req_op == 2'b10);
    b_signed     = (bus.req_op == 2'b01);
    a_neg        = a_signed && bus.req_a[XLEN-1];
    b_neg        = b_signed && bus.req_b[XLEN-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    a_mag        = a_neg ? -bus.req_a : bus.req_a;
    b_mag        = b_neg ? -bus.req_b : bus.req_b;
    operand_zero = (bus.req_a == '0) || (bus.req_b == '0);
    prod_fixed   = neg_q ? -prod_q : prod_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    data_d  = data_q;
    prod_d  = prod_q;

    if (bus.flush) begin
      // A launched multiply must still be drained so its done pulse is not taken as ours.
      unique case (state_q)
        StIssue: state_d = StDrain;
        StWait:  state_d = bus.mul_done ? StIdle : StDrain;
        StDrain: state_d = bus.mul_done ? StIdle : StDrain;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_d  = bus.req_op;
            tag_d = bus.req_tag;
            neg_d = a_neg ^ b_neg;
            in1_d = a_mag;
            in2_d = b_mag;
            if (operand_zero) begin
              data_d  = '0;
              state_d = StResp;
            end else begin
              state_d = StIssue;
            end
          end
        end
        StIssue: state_d = StWait;
        StWait: begin
          if (bus.mul_done) begin
            prod_d  = bus.mul_product;
            state_d = StFix;
          end
        end
        StFix: begin
          prod_d  = prod_fixed;
          data_d  = (op_q == 2'b00) ? prod_fixed[XLEN-1:0] : prod_fixed[PW-1:XLEN];
          state_d = StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_d = StIdle;
          end
        end
        StDrain: begin
          if (bus.mul_done) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      data_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      data_q  <= data_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.mul_start = (state_q == StIssue);
    bus.rsp_valid = (state_q == StResp);
    bus.mul_in1   = in1_q;
    bus.mul_in2   = in2_q;
    bus.rsp_data  = data_q;
    bus.rsp_tag   = tag_q;
  end

endmodule

// File: tb/tb_mul_issue.sv
module tb_mul_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  // Expected responses in order: {data[31:0], tag[4:0]}.
  logic [36:0] exp_q[$];

  mul_issue_if #(.XLEN(32), .TAG_W(5)) bus ();

  mul_issue #(.XLEN(32), .TAG_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference result: extend each operand per its signedness, multiply to 64 bits.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
    if (sgn && v[31]) return 32'd0 - v;
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response checker: every cycle a response is presented it must match the oldest
  // outstanding expectation; it retires on rsp_ready.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_rsp: rsp_valid=1 data=%h tag=%h, expected no response",
                 bus.rsp_data, bus.rsp_tag);
      end else begin
        chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0][36:5]));
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(exp_q[0][4:0]));
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // fmode: 0 none, 1 flush in WAIT, 2 flush in ISSUE, 3 flush with mul_done in WAIT.
  task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input int lat, input int hold, input int fmode,
                     input bit use_lit, input logic [31:0] lit);
    int n;
    int fm;
    logic [31:0] exp_d, ma, mb;
    bit fast;
    fast  = (a == 32'h0) || (b == 32'h0);
    fm    = fast ? 0 : fmode;
    exp_d = use_lit ? lit : ref_mul(op, a, b);
    ma    = mag(a, op == 2'b01 || op == 2'b10);
    mb    = mag(b, op == 2'b01);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
    if (fm == 0) exp_q.push_back({exp_d, tag});
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    tick();
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    if (fast) begin
      chk("fast_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("fast_no_start", 64'(bus.mul_start), 64'd0);
    end else begin
      chk("mul_start", 64'(bus.mul_start), 64'd1);
      chk("mul_in1", 64'(bus.mul_in1), 64'(ma));
      chk("mul_in2", 64'(bus.mul_in2), 64'(mb));
      if (fm == 2) bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("start_once", 64'(bus.mul_start), 64'd0);
      if (fm == 1) begin
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
      end
      repeat (lat) begin
        chk("no_early_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("in1_stable", 64'(bus.mul_in1), 64'(ma));
        bus.mul_product = {$urandom, $urandom};
        tick();
      end
      bus.mul_done    = 1'b1;
      bus.mul_product = {32'b0, ma} * {32'b0, mb};
      if (fm == 3) bus.flush = 1'b1;
      tick();
      bus.mul_done    = 1'b0;
      bus.flush       = 1'b0;
      bus.mul_product = {$urandom, $urandom};
      if (fm != 0) begin
        chk("flush_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("flush_ready", 64'(bus.req_ready), 64'd1);
        return;
      end
      chk("fix_no_rsp", 64'(bus.rsp_valid), 64'd0);
      tick();
      chk("rsp_latency", 64'(bus.rsp_valid), 64'd1);
    end
    repeat (hold) begin
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("retired", 64'(bus.rsp_valid), 64'd0);
    chk("retire_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_tag     = '0;
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    bus.rsp_ready   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mul_in1", 64'(bus.mul_in1), 64'd0);
    chk("rst_mul_in2", 64'(bus.mul_in2), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    rst = 1'b0;
    tick();

    // Hand-computed cases.
    txn(2'b00, 32'd7, 32'd6, 5'h11, 2, 0, 0, 1'b1, 32'h0000_002A);
    txn(2'b01, 32'h8000_0000, 32'h8000_0000, 5'h03, 1, 1, 0, 1'b1, 32'h4000_0000);
    txn(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 0, 0, 0, 1'b1, 32'h0000_0001);
    txn(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0A, 3, 2, 0, 1'b1, 32'hFFFF_FFFF);
    txn(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h15, 1, 0, 0, 1'b1, 32'hFFFF_FFFE);
    txn(2'b01, 32'h0, 32'h1234_5678, 5'h07, 0, 0, 0, 1'b1, 32'h0);
    txn(2'b01, 32'hFFFF_FFFD, 32'd5, 5'h09, 2, 5, 0, 1'b1, 32'hFFFF_FFFF);
    txn(2'b00, 32'hFFFF_FFFD, 32'd5, 5'h0B, 0, 0, 0, 1'b1, 32'hFFFF_FFF1);
    // Flush scenarios, each followed by a normal op.
    txn(2'b11, 32'd9, 32'd9, 5'h01, 3, 0, 1, 1'b0, 32'h0);
    txn(2'b00, 32'd3, 32'd5, 5'h02, 1, 0, 0, 1'b1, 32'd15);
    txn(2'b01, 32'd9, 32'd9, 5'h04, 2, 0, 2, 1'b0, 32'h0);
    txn(2'b01, 32'd9, 32'hFFFF_FFFF, 5'h05, 0, 0, 3, 1'b0, 32'h0);
    txn(2'b01, 32'd9, 32'hFFFF_FFFF, 5'h06, 0, 0, 0, 1'b1, 32'hFFFF_FFFF);

    // Stray mul_done while idle must be ignored.
    bus.mul_done    = 1'b1;
    bus.mul_product = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    bus.mul_done = 1'b0;
    chk("stray_done_ready", 64'(bus.req_ready), 64'd1);
    chk("stray_done_no_rsp", 64'(bus.rsp_valid), 64'd0);

    // Reset while waiting; the late mul_done must be ignored.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd200;
    bus.req_tag   = 5'h1C;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst_in1", 64'(bus.mul_in1), 64'd0);
    chk("midrst_tag", 64'(bus.rsp_tag), 64'd0);
    bus.mul_done    = 1'b1;
    bus.mul_product = 64'd20000;
    tick();
    bus.mul_done = 1'b0;
    repeat (3) begin
      chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("midrst_no_start", 64'(bus.mul_start), 64'd0);
      tick();
    end
    txn(2'b11, 32'd100, 32'd200, 5'h1D, 1, 0, 0, 1'b1, 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      int fmode;
      fmode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      txn(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 3)), fmode, 1'b0, 32'h0);
    end

    tick();
    chk("all_retired", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
